pwm_capture: RTL

- Bus-mapped PWM input capture. It is the receive-side counterpart of the team's PWM generator.
- Samples an external pulse train and measures, in clk cycles, the high time and period of each completed cycle.
- Results are exposed on the same simple valid/ready/wstrb/addr/wdata/rdata peripheral bus used by the other modules.

---
 rtl/pwm_capture.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: bus-mapped PWM input capture measuring high time and period in clk cycles.
// Define PWM_CAPTURE_IRQ_EN to add the irq output and the CTRL.IE enable bit.
module pwm_capture #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
`ifdef PWM_CAPTURE_IRQ_EN
  output logic        irq,
`endif
  input  logic        in
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, p_q, rise, fall;
  logic                   en_q, ie_q, valid_q, ovf_q, armed_q, ovf_pend_q;
  logic [CNT_WIDTH-1:0]   cnt_q, hi_q, high_q, period_q, cnt_d;
  logic [31:0]            count_q, ctrl_rd, rdata_d;
  logic                   req, ctrl_wr, clr, cap;
  logic                   unused;
  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~p_q;
  assign fall    = ~s & p_q;
  assign req     = valid & ~ready;
  assign ctrl_wr = req & wstrb[0] & (addr[3:2] == 2'd0);
  assign clr     = ctrl_wr & wdata[1];
  assign cap     = en_q & rise & armed_q;
  // Saturating increment; reused for cnt, the high-time snapshot and the period.
  assign cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
`ifdef PWM_CAPTURE_IRQ_EN
  assign unused  = ^{addr[31:4], addr[1:0], wdata[31:3]};
`else
  assign unused  = ^{addr[31:4], addr[1:0], wdata[31:2]};
`endif
  always_comb begin
    ctrl_rd     = 32'd0;
    ctrl_rd[0]  = en_q;
    ctrl_rd[2]  = ie_q;
    ctrl_rd[8]  = valid_q;
    ctrl_rd[9]  = ovf_q;
    ctrl_rd[10] = s;
    rdata_d = addr[3:2] == 2'd0 ? ctrl_rd :
              addr[3:2] == 2'd1 ? 32'(high_q) :
              addr[3:2] == 2'd2 ? 32'(period_q) : count_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= req;
      rdata <= (req && wstrb == 4'd0) ? rdata_d : 32'd0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      p_q    <= s;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q <= 1'b0;
      ie_q <= 1'b0;
    end else if (ctrl_wr) begin
      en_q <= wdata[0];
`ifdef PWM_CAPTURE_IRQ_EN
      ie_q <= wdata[2];
`endif
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      ovf_pend_q <= 1'b0;
      armed_q    <= 1'b0;
    end else if (!en_q) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      ovf_pend_q <= 1'b0;
      armed_q    <= 1'b0;
    end else if (rise) begin
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_q | (&cnt_d);
      if (fall) hi_q <= cnt_d;
    end
  end
  // A capture on the same edge as CLR wins, counting from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      high_q   <= '0;
      period_q <= '0;
      count_q  <= 32'd0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (cap) begin
      high_q   <= hi_q;
      period_q <= cnt_d;
      count_q  <= (clr ? 32'd0 : count_q) + 32'd1;
      valid_q  <= 1'b1;
      ovf_q    <= ovf_pend_q;
    end else if (clr) begin
      count_q  <= 32'd0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end
  end
`ifdef PWM_CAPTURE_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= valid_q & ie_q;
  end
`endif
endmodule
